// File: rtl/crossing_game_ctrl_pkg.sv
// Shared definitions for the lane-crossing game: state encodings used by the
// controller and the LED decode, plus board geometry for the datapath.
package crossing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GAME_1 = 2'd1,
        ST_GAME_2 = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int ROWS       = 8;
    localparam int WIN_SCORE  = 10;
    localparam int ROW_HEIGHT = 60;
    localparam int SCORE_W    = 4;

    // The turn passes to whichever game state is not the current one.
    function automatic state_t other_game(input state_t s);
        return (s == ST_GAME_1) ? ST_GAME_2 : ST_GAME_1;
    endfunction

endpackage

// File: rtl/crossing_game_ctrl_if.sv
// Controller <-> VGA drawing/collision datapath signals.
interface crossing_game_ctrl_if #(
    parameter int ROWS = crossing_pkg::ROWS
);
    import crossing_pkg::*;

    logic                    collide;
    state_t                  state;
    logic [$clog2(ROWS)-1:0] player_row;
    logic [SCORE_W-1:0]      p1_score;
    logic [SCORE_W-1:0]      p2_score;
    logic                    move_tick;
    logic                    lanes_init;
    logic                    score_pulse;

    modport master (
        input  collide,
        output state, player_row, p1_score, p2_score,
        output move_tick, lanes_init, score_pulse
    );

    modport slave (
        output collide,
        input  state, player_row, p1_score, p2_score,
        input  move_tick, lanes_init, score_pulse
    );

endinterface

// File: rtl/crossing_game_ctrl_btn_sampler.sv
// One raw button: 2-FF synchronizer, sample register updated only on the
// button tick, and a one-cycle press pulse on a 0->1 change between samples.
module btn_sampler (
    input  logic board_clk,
    input  logic rst,
    input  logic btn,
    input  logic tick,
    output logic press
);

    logic [1:0] sync;
    logic       sample;

    // Synchronize every cycle; resample and edge-detect only on tick so a held
    // button yields exactly one press.
    always_ff @(posedge board_clk or posedge rst) begin
        if (rst) begin
            sync   <= 2'b00;
            sample <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (tick) begin
                sample <= sync[1];
                press  <= sync[1] & ~sample;
            end
        end
    end

endmodule

// File: rtl/crossing_game_ctrl.sv
// Game sequencer: pacing divider, start/button conditioning, game FSM,
// player row and per-player scores. All outputs come straight from flops.
module crossing_game_ctrl #(
    parameter int BTN_DIV_W  = 18,
    parameter int MOVE_DIV_W = 21,
    parameter int ROWS       = crossing_pkg::ROWS,
    parameter int WIN_SCORE  = crossing_pkg::WIN_SCORE
) (
    input  logic                   board_clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   btn_up,
    input  logic                   btn_down,
    crossing_game_ctrl_if.master   bus
);
    import crossing_pkg::*;

    localparam int                  ROW_W     = $clog2(ROWS);
    localparam logic [ROW_W-1:0]    ROW_START = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]    ROW_FIRST = ROW_W'(1);
    localparam logic [SCORE_W-1:0]  WIN       = SCORE_W'(WIN_SCORE);

    logic [1:0]            rst_ff;
    logic                  rst_int;
    logic [MOVE_DIV_W-1:0] div;
    logic                  btn_tick;
    logic [1:0]            start_sync;
    logic                  start_s;
    logic                  up_press;
    logic                  down_press;

    state_t                state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [SCORE_W-1:0]    p1_q, p1_d, p2_q, p2_d;
    logic                  init_q, init_d;
    logic                  score_q, score_d;
    logic                  tick_q;
    logic                  collision;
    logic [SCORE_W-1:0]    score_inc;

    // Reset asserts immediately but releases two board_clk edges later, so
    // every flop leaves reset on the same clean edge.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) rst_ff <= 2'b11;
        else       rst_ff <= {rst_ff[0], 1'b0};
    end
    assign rst_int = rst_ff[1];

    // Free-running pacing divider; the move tick is registered off its terminal count.
    always_ff @(posedge board_clk or posedge rst_int) begin
        if (rst_int) begin
            div    <= '0;
            tick_q <= 1'b0;
        end else begin
            div    <= div + MOVE_DIV_W'(1);
            tick_q <= &div;
        end
    end
    assign btn_tick = &div[BTN_DIV_W-1:0];

    // Start switch is a level from another domain: plain 2-FF synchronizer.
    always_ff @(posedge board_clk or posedge rst_int) begin
        if (rst_int) start_sync <= 2'b00;
        else         start_sync <= {start_sync[0], start};
    end
    assign start_s = start_sync[1];

    btn_sampler u_btn_up (
        .board_clk (board_clk),
        .rst       (rst_int),
        .btn       (btn_up),
        .tick      (btn_tick),
        .press     (up_press)
    );

    btn_sampler u_btn_down (
        .board_clk (board_clk),
        .rst       (rst_int),
        .btn       (btn_down),
        .tick      (btn_tick),
        .press     (down_press)
    );

    // Collisions only matter inside a lane; the active player's score is the one bumped.
    assign collision = bus.collide && (row_q != '0) && (row_q != ROW_START);
    assign score_inc = ((state_q == ST_GAME_2) ? p2_q : p1_q) + SCORE_W'(1);

    // Next state, row and scores; abort beats collision beats press.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        init_d  = 1'b0;
        score_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                row_d = ROW_START;
                p1_d  = '0;
                p2_d  = '0;
                if (start_s) begin
                    state_d = ST_GAME_1;
                    init_d  = 1'b1;
                end
            end
            ST_GAME_1, ST_GAME_2: begin
                if (!start_s) begin
                    state_d = ST_IDLE;
                    row_d   = ROW_START;
                    p1_d    = '0;
                    p2_d    = '0;
                end else if (collision) begin
                    state_d = other_game(state_q);
                    row_d   = ROW_START;
                    init_d  = 1'b1;
                end else if (up_press && !down_press) begin
                    if (row_q <= ROW_FIRST) begin
                        // Stepping into the goal scores and returns to start in
                        // the same edge, so the row never rests at 0.
                        row_d   = ROW_START;
                        score_d = 1'b1;
                        if (state_q == ST_GAME_1) p1_d = score_inc;
                        else                      p2_d = score_inc;
                        if (score_inc == WIN) state_d = ST_DONE;
                    end else begin
                        row_d = row_q - ROW_W'(1);
                    end
                end else if (down_press && !up_press) begin
                    if (row_q != ROW_START) row_d = row_q + ROW_W'(1);
                end
            end
            ST_DONE: begin
                if (!start_s) begin
                    state_d = ST_IDLE;
                    row_d   = ROW_START;
                    p1_d    = '0;
                    p2_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Game registers, including the one-cycle event pulses.
    always_ff @(posedge board_clk or posedge rst_int) begin
        if (rst_int) begin
            state_q <= ST_IDLE;
            row_q   <= ROW_START;
            p1_q    <= '0;
            p2_q    <= '0;
            init_q  <= 1'b0;
            score_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            init_q  <= init_d;
            score_q <= score_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.player_row  = row_q;
    assign bus.p1_score    = p1_q;
    assign bus.p2_score    = p2_q;
    assign bus.move_tick   = tick_q;
    assign bus.lanes_init  = init_q;
    assign bus.score_pulse = score_q;

endmodule

// File: tb/tb_crossing_game_ctrl.sv
// Scoreboard bench: stimulus pushes expected output events, a negedge monitor
// pops one whenever state/row/scores change or a pulse is present.
module tb_crossing_game_ctrl;

    typedef struct packed {
        logic [1:0] st;
        logic [2:0] row;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       li;
        logic       sp;
    } obs_t;

    logic board_clk;
    logic reset;
    logic start;
    logic btn_up;
    logic btn_down;

    crossing_game_ctrl_if #(.ROWS(8)) bus ();

    crossing_game_ctrl #(
        .BTN_DIV_W  (2),
        .MOVE_DIV_W (4),
        .ROWS       (8),
        .WIN_SCORE  (3)
    ) dut (
        .board_clk (board_clk),
        .reset     (reset),
        .start     (start),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .bus       (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    obs_t exp_q[$];
    obs_t cur, prev, e;
    bit   mon_en = 0;

    // Reference pacing: reset release delay and divider.
    logic [1:0] mr;
    logic [3:0] mdiv;
    logic       mtick;

    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    always @(posedge board_clk or posedge reset) begin
        if (reset) begin
            mr    <= 2'b11;
            mdiv  <= 4'd0;
            mtick <= 1'b0;
        end else begin
            mtick <= !mr[1] && (mdiv == 4'd15);
            if (!mr[1]) mdiv <= mdiv + 4'd1;
            mr <= {mr[0], 1'b0};
        end
    end

    always @(negedge board_clk) begin
        if (mon_en) begin
            cur.st  = bus.state;
            cur.row = bus.player_row;
            cur.p1  = bus.p1_score;
            cur.p2  = bus.p2_score;
            cur.li  = bus.lanes_init;
            cur.sp  = bus.score_pulse;
            checks++;
            if (bus.move_tick !== mtick) begin
                failures++;
                $display("FAIL move_tick @%0t: got %0b expected %0b", $time, bus.move_tick, mtick);
            end
            if ({cur.st, cur.row, cur.p1, cur.p2} != {prev.st, prev.row, prev.p1, prev.p2}
                || cur.li || cur.sp) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event @%0t: got st=%0d row=%0d p1=%0d p2=%0d li=%0b sp=%0b, expected no change",
                             $time, cur.st, cur.row, cur.p1, cur.p2, cur.li, cur.sp);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        failures++;
                        $display("FAIL event @%0t: got st=%0d row=%0d p1=%0d p2=%0d li=%0b sp=%0b, expected st=%0d row=%0d p1=%0d p2=%0d li=%0b sp=%0b",
                                 $time, cur.st, cur.row, cur.p1, cur.p2, cur.li, cur.sp,
                                 e.st, e.row, e.p1, e.p2, e.li, e.sp);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic push(input int st, input int row, input int p1, input int p2,
                        input int li, input int sp);
        obs_t x;
        x.st  = 2'(st);
        x.row = 3'(row);
        x.p1  = 4'(p1);
        x.p2  = 4'(p2);
        x.li  = 1'(li);
        x.sp  = 1'(sp);
        exp_q.push_back(x);
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge board_clk);
    endtask

    // Hold long enough to cross sync + sampling skew, then release fully.
    task automatic press(input bit u, input bit d);
        btn_up   = u;
        btn_down = d;
        idle(8);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        idle(8);
    endtask

    // Six up presses from the start row: rows 6..1.
    task automatic climb(input int st, input int p1, input int p2);
        for (int r = 6; r >= 1; r--) begin
            push(st, r, p1, p2, 0, 0);
            press(1'b1, 1'b0);
        end
    endtask

    // Up press whose press pulse lands in the same cycle as collide.
    task automatic up_with_collide();
        bit hit;
        hit    = 1'b0;
        btn_up = 1'b1;
        repeat (3) @(posedge board_clk);
        for (int i = 0; i < 16 && !hit; i++) begin
            @(negedge board_clk);
            if (mdiv[1:0] == 2'd0) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL align_tick: got no sample tick, expected one within 16 cycles");
        end
        bus.collide = 1'b1;
        @(negedge board_clk);
        bus.collide = 1'b0;
        idle(6);
        btn_up = 1'b0;
        idle(8);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        btn_up      = 1'b0;
        btn_down    = 1'b0;
        bus.collide = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(3);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_row", int'(bus.player_row), 7);
        chk("rst_p1", int'(bus.p1_score), 0);
        chk("rst_p2", int'(bus.p2_score), 0);
        chk("rst_lanes_init", int'(bus.lanes_init), 0);
        chk("rst_score_pulse", int'(bus.score_pulse), 0);
        prev = '{st: 2'd0, row: 3'd7, p1: 4'd0, p2: 4'd0, li: 1'b0, sp: 1'b0};
        mon_en = 1'b1;

        // Idle: divider runs, nothing else moves.
        idle(64);

        // Start, then a full crossing by player 1.
        push(1, 7, 0, 0, 1, 0);
        start = 1'b1;
        idle(8);
        climb(1, 0, 0);
        push(1, 7, 1, 0, 0, 1);
        press(1'b1, 1'b0);

        // Collision in a lane hands the turn over; collide at start row ignored.
        push(1, 6, 1, 0, 0, 0);
        press(1'b1, 1'b0);
        push(2, 7, 1, 0, 1, 0);
        bus.collide = 1'b1;
        idle(4);
        bus.collide = 1'b0;
        idle(4);

        // Both buttons together, and down at the start row: no change.
        press(1'b1, 1'b1);
        press(1'b0, 1'b1);

        // Collision beats a scoring press at row 1.
        climb(2, 1, 0);
        push(1, 7, 1, 0, 1, 0);
        up_with_collide();

        // Player 1 reaches the win score; DONE ignores presses.
        climb(1, 1, 0);
        push(1, 7, 2, 0, 0, 1);
        press(1'b1, 1'b0);
        climb(1, 2, 0);
        push(3, 7, 3, 0, 0, 1);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        push(0, 7, 0, 0, 0, 0);
        start = 1'b0;
        idle(8);

        // Abort mid-GAME_2 with both scores non-zero.
        push(1, 7, 0, 0, 1, 0);
        start = 1'b1;
        idle(8);
        climb(1, 0, 0);
        push(1, 7, 1, 0, 0, 1);
        press(1'b1, 1'b0);
        push(1, 6, 1, 0, 0, 0);
        press(1'b1, 1'b0);
        push(2, 7, 1, 0, 1, 0);
        bus.collide = 1'b1;
        idle(1);
        bus.collide = 1'b0;
        idle(4);
        climb(2, 1, 0);
        push(2, 7, 1, 1, 0, 1);
        press(1'b1, 1'b0);
        push(2, 6, 1, 1, 0, 0);
        press(1'b1, 1'b0);
        push(0, 7, 0, 0, 0, 0);
        start = 1'b0;
        idle(8);

        // Short asynchronous reset between clock edges mid-game.
        push(1, 7, 0, 0, 1, 0);
        start = 1'b1;
        idle(8);
        push(1, 6, 0, 0, 0, 0);
        press(1'b1, 1'b0);
        push(0, 7, 0, 0, 0, 0);
        @(posedge board_clk);
        #1;
        reset = 1'b1;
        start = 1'b0;
        #2;
        chk("async_state", int'(bus.state), 0);
        chk("async_row", int'(bus.player_row), 7);
        chk("async_p1", int'(bus.p1_score), 0);
        chk("async_lanes_init", int'(bus.lanes_init), 0);
        chk("async_move_tick", int'(bus.move_tick), 0);
        #1;
        reset = 1'b0;
        idle(20);

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crossing_game_ctrl.md
# crossing_game_ctrl

Game sequencer for the two-player lane-crossing VGA game. Owns the game state machine, the player's row position, per-player scores, and the timing ticks that pace block motion and button sampling. Sits between the board inputs (start switch, up/down buttons) and the VGA drawing/collision datapath. Consumes a collision flag from that datapath and drives the LEDs and seven-segment score display.

## Interface
Parameters:
- BTN_DIV_W, 18, button sample tick period = 2^BTN_DIV_W board_clk cycles
- MOVE_DIV_W, 21, block move tick period = 2^MOVE_DIV_W cycles; must be > BTN_DIV_W
- ROWS, 8, player rows; row 0 = goal (top), row ROWS-1 = start (bottom), rows 1..ROWS-2 = lanes
- WIN_SCORE, 10, score that ends the game

Ports:
- board_clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high
- start  in  1  start switch, level, asynchronous to board_clk
- btn_up  in  1  up button, raw
- btn_down  in  1  down button, raw
- collide  in  1  datapath flag: player box overlaps a block in the current row, level
- state  out  2  0=IDLE, 1=GAME_1, 2=GAME_2, 3=DONE
- player_row  out  $clog2(ROWS)  current player row
- p1_score  out  4  player 1 crossings
- p2_score  out  4  player 2 crossings
- move_tick  out  1  one-cycle pulse; datapath advances blocks on it
- lanes_init  out  1  one-cycle pulse; datapath reloads block start positions
- score_pulse  out  1  one-cycle pulse on each successful crossing

## Operation
- Free-running divider, MOVE_DIV_W bits. btn_tick = low BTN_DIV_W bits all ones. move_tick = all bits ones. The divider runs in every state.
- Buttons and start: 2-FF synchronizers. Buttons are resampled only on btn_tick. A press is a 0→1 change between consecutive samples. Each press yields one move; holding a button does not repeat.
- States:
  - IDLE: scores 0, player_row = ROWS-1. Go to GAME_1 when synced start = 1, and pulse lanes_init in the same cycle.
  - GAME_1 / GAME_2: the active player moves.
    - Up press: row−1.
    - Down press: row+1, saturating at ROWS-1.
    - Both pressed in the same sample: ignored.
    - Reaching row 0: active score +1, score_pulse, row ← ROWS-1, stay in the state.
    - Collision: row ← ROWS-1, switch to the other GAME state, pulse lanes_init. A collision counts only when collide = 1 and the row is within 1..ROWS-2.
    - A score that reaches WIN_SCORE moves to DONE instead.
  - DONE: scores and row frozen, press events ignored. Go to IDLE when synced start = 0.
  - start = 0 during GAME_1 or GAME_2: go to IDLE, which clears scores and row.
- Priority within one cycle: start-low abort > collision > press.
- Scores are 4-bit and never exceed WIN_SCORE (≤ 15).

## Timing
- Reset values:
  - state = IDLE, player_row = ROWS-1, scores = 0
  - move_tick = lanes_init = score_pulse = 0
  - divider = 0
- Reset is asserted asynchronously and released synchronously through the board_clk domain. Reset mid-game returns to IDLE immediately, with no pulses.
- All outputs are registered.
- A press is visible at player_row on the board_clk edge after the btn_tick that samples it. Synchronizer latency is 2 cycles plus up to 2^BTN_DIV_W cycles of sampling skew.
- collide to row/state update: 1 cycle, with no synchronizer because collide is in the same domain.
- Goal handling: the row register never holds 0 for more than one cycle. The scoring cycle writes ROWS-1 directly.
- move_tick and btn_tick can coincide. They are independent and both are honoured.
- lanes_init and move_tick in the same cycle: the datapath gives lanes_init priority.

## Structure
- Package crossing_pkg holds:
  - state encodings (ST_IDLE, ST_GAME_1, ST_GAME_2, ST_DONE), shared with the LED decode
  - ROWS, WIN_SCORE, ROW_HEIGHT = 60 for the datapath
- Sub-module btn_sampler holds the synchronizer, tick-gated sample register, and rising-edge detect. It is instantiated once per button.
- The controller body holds the divider, FSM, row register and score registers.

## Test plan
Bench parameters: BTN_DIV_W = 2, MOVE_DIV_W = 4, ROWS = 8, WIN_SCORE = 3.
- Divider and idle: reset, then run 64 cycles with start = 0 → move_tick pulses every 16 cycles, 1 cycle wide; state = 0, row = 7, no lanes_init.
- Start and crossing: start = 1 → lanes_init once, state = 1. Then 7 separated up presses → row 6..1, then score_pulse, p1_score = 1, row = 7.
- Collision and turn switch: in GAME_1, 1 up (row 6), collide = 1 → next cycle row = 7, state = 2, lanes_init. collide = 1 at row 7 → ignored.
- Simultaneous inputs:
  - up and down together → row unchanged.
  - down at row 7 → row stays 7.
  - collide in the same cycle as an up press at row 1 → collision wins, p2_score unchanged.
- Win and restart: p1 scores 3 → state = 3, p1_score = 3, presses ignored. start = 0 → IDLE, scores 0.
- Abort and async reset:
  - start = 0 mid-GAME_2 → IDLE, scores cleared.
  - reset pulse of 3 ns between clock edges mid-game → outputs return to reset values without waiting for a clock edge.
